lfsr_encrypt_tx: RTL and testbench
==================================

Name: lfsr_encrypt_tx

Overview:
- Packet transmitter/encryptor; the transmit-side counterpart of the LFSR decryption datapath.
- Takes a seed, a tap selection and a stream of plaintext payload bytes.
- Emits one fixed-length packet of encrypted bytes: PRE_LEN preamble bytes (plaintext 8'h7E) followed by payload bytes.
- Each byte is XORed with a key derived from a 5-bit LFSR that advances once per emitted byte. Output feeds the receiver's input FIFO push side.

Parameters:
- PKT_LEN, 32, total bytes per packet (preamble + payload).
- PRE_LEN, 7, preamble byte count; plaintext preamble byte is 8'h7E.
- PAY_KEY_HI, 3'b100, upper 3 key bits during payload (preamble uses 3'b000).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  begin a packet; sampled in IDLE only.
- seed  input  5  initial LFSR state; captured on accepted start.
- tap_sel  input  3  polynomial index: 0=5'h1E, 1=5'h1D, 2=5'h1B, 3=5'h17, 4=5'h14, 5=5'h12; captured on accepted start.
- plainByte  input  8  payload plaintext from source.
- plainValid  input  1  plainByte valid.
- plainReady  output  1  source handshake; transfer when plainValid && plainReady.
- encryptByte  output  8  encrypted byte (registered).
- validOut  output  1  encryptByte valid.
- outReady  input  1  sink accepts; transfer when validOut && outReady.
- busy  output  1  packet in progress (state != IDLE).
- packetDone  output  1  one-cycle pulse after the last byte is accepted.
- cfgErr  output  1  one-cycle pulse when start is rejected.

Behaviour:
- Clocking and reset: single clock domain (clk). Reset is synchronous and active-high (rst).
- Reset values: validOut=0, encryptByte=0, plainReady=0, busy=0, packetDone=0, cfgErr=0, byte count=0, LFSR=0, state=IDLE. Asserting rst mid-packet aborts immediately with no further bytes; the next packet needs a new start.
- LFSR: on advance, state <= {state[3:0], ^(state & taps)}. Loaded with seed on accepted start.
- Key byte: {3'b000, lfsr} for byte index < PRE_LEN; {PAY_KEY_HI, lfsr} otherwise. encryptByte = plaintext ^ key.
- Output register: a new byte loads when validOut==0 or (validOut && outReady). On load, the LFSR advances once and byteCnt increments. An unaccepted byte holds encryptByte and validOut stable until outReady.
- FSM states:
  - IDLE: start && seed!=0 && tap_sel<=5 -> capture config -> PRE. Otherwise, start -> cfgErr pulse and stay in IDLE.
  - PRE: load 8'h7E ^ key each load opportunity. After loading byte PRE_LEN-1 -> PAY.
  - PAY: plainReady = load opportunity (combinational from validOut/outReady/state). On plainValid && plainReady, load plainByte ^ key. No plainValid means no load; validOut drops once the held byte is consumed (bubbles allowed). After loading byte PKT_LEN-1 -> DRAIN.
  - DRAIN: plainReady=0. When the last byte is accepted -> packetDone pulse, validOut=0 -> IDLE.
- Latency: start accepted at cycle N -> first byte with validOut=1 at N+1. With outReady held at 1 and plainValid at 1, one byte per cycle, no gaps: PKT_LEN consecutive valid cycles, then packetDone the cycle after the last acceptance.
- The first byte equals 8'h7E ^ {3'b000, seed}, so a receiver can recover the seed from byte 0.
- start while busy: ignored, no cfgErr.
- Simultaneous load and accept in the same cycle: the new byte replaces the accepted byte, with no bubble.
- byteCnt width: $clog2(PKT_LEN+1); no wrap within a packet; cleared on accepted start.
- plainByte is not sampled outside PAY.

Test Plan:
- seed=5'h01, tap_sel=0, outReady=1: bytes 0..2 = 8'h7F, 8'h7C, 8'h7B; 7 preamble bytes, then 25 payload bytes; packetDone one cycle after byte 31.
- Payload ramp 8'h00..8'h18 against a bit-exact reference model for all 6 tap_sel values, seeds 5'h01 and 5'h1F: every encryptByte matches; decrypting with the same seed/taps returns the plaintext.
- outReady randomly deasserted 50% of cycles: encryptByte/validOut stable while stalled; LFSR advances exactly 32 times; byte sequence identical to the no-stall run.
- plainValid gaps in PAY: plainReady asserted only while loadable; no byte duplicated or dropped; sequence unchanged.
- seed=0 or tap_sel=6/7 with start: cfgErr pulses one cycle, busy stays 0. start during busy: no effect.
- rst asserted at byte 10: next cycle validOut=0, busy=0. A new start with seed=5'h01 reproduces byte 0 = 8'h7F.

Source files
------------

// File: rtl/lfsr_encrypt_tx.sv
// lfsr_encrypt_tx: transmit-side packet encryptor. Emits PKT_LEN bytes per
// packet (PRE_LEN preamble bytes of 8'h7E, then payload), each XORed with a
// key built from a 5-bit Fibonacci LFSR that steps once per emitted byte.
module lfsr_encrypt_tx #(
  parameter int         PKT_LEN    = 32,
  parameter int         PRE_LEN    = 7,
  parameter logic [2:0] PAY_KEY_HI = 3'b100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] seed,
  input  logic [2:0] tap_sel,
  input  logic [7:0] plainByte,
  input  logic       plainValid,
  output logic       plainReady,
  output logic [7:0] encryptByte,
  output logic       validOut,
  input  logic       outReady,
  output logic       busy,
  output logic       packetDone,
  output logic       cfgErr
);

  localparam int CW = $clog2(PKT_LEN + 1);
  localparam logic [7:0] PRE_BYTE = 8'h7E;

  typedef enum logic [1:0] {IDLE, PRE, PAY, DRAIN} state_t;

  state_t        state;
  logic [4:0]    lfsr;
  logic [4:0]    taps;
  logic [CW-1:0] byte_cnt;

  logic          cfg_ok;
  logic          load_ok;
  logic          do_load;
  logic [4:0]    cur_lfsr;
  logic [4:0]    cur_taps;
  logic [CW-1:0] cur_idx;
  logic [7:0]    key;
  logic [7:0]    src;
  logic [4:0]    lfsr_nxt;
  state_t        state_after_load;

  // Polynomial table indexed by tap_sel; out-of-range values are rejected
  // before they are ever captured, so the default is never loaded.
  function automatic logic [4:0] tap_of(input logic [2:0] sel);
    case (sel)
      3'd0:    tap_of = 5'h1E;
      3'd1:    tap_of = 5'h1D;
      3'd2:    tap_of = 5'h1B;
      3'd3:    tap_of = 5'h17;
      3'd4:    tap_of = 5'h14;
      3'd5:    tap_of = 5'h12;
      default: tap_of = 5'h00;
    endcase
  endfunction

  assign cfg_ok  = (seed != 5'd0) && (tap_sel <= 3'd5);
  // Output register can take a new byte when empty or being drained this cycle.
  assign load_ok = !validOut || outReady;
  assign plainReady = (state == PAY) && load_ok;
  assign busy    = (state != IDLE);

  // Byte 0 is loaded on the start edge itself, so in IDLE the key comes
  // straight from seed/tap_sel rather than from the (not yet loaded) registers.
  always_comb begin
    cur_lfsr = (state == IDLE) ? seed : lfsr;
    cur_taps = (state == IDLE) ? tap_of(tap_sel) : taps;
    cur_idx  = (state == IDLE) ? '0 : byte_cnt;
    key      = {(cur_idx < CW'(PRE_LEN)) ? 3'b000 : PAY_KEY_HI, cur_lfsr};
    src      = (state == PAY) ? plainByte : PRE_BYTE;
    lfsr_nxt = {cur_lfsr[3:0], ^(cur_lfsr & cur_taps)};
    do_load  = ((state == IDLE) && start && cfg_ok) ||
               ((state == PRE)  && load_ok) ||
               ((state == PAY)  && plainValid && plainReady);
    if (cur_idx == CW'(PKT_LEN - 1))
      state_after_load = DRAIN;
    else if (cur_idx >= CW'(PRE_LEN - 1))
      state_after_load = PAY;
    else
      state_after_load = PRE;
  end

  // Packet FSM, output register, LFSR and byte counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lfsr        <= '0;
      taps        <= '0;
      byte_cnt    <= '0;
      encryptByte <= '0;
      validOut    <= 1'b0;
      packetDone  <= 1'b0;
      cfgErr      <= 1'b0;
    end else begin
      packetDone <= 1'b0;
      cfgErr     <= 1'b0;

      // A load replaces an accepted byte in the same cycle (no bubble); an
      // accept with nothing to load empties the register.
      if (do_load) begin
        encryptByte <= src ^ key;
        validOut    <= 1'b1;
        lfsr        <= lfsr_nxt;
        byte_cnt    <= cur_idx + 1'b1;
      end else if (validOut && outReady) begin
        validOut <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              taps  <= tap_of(tap_sel);
              state <= state_after_load;
            end else begin
              cfgErr <= 1'b1;
            end
          end
        end
        PRE, PAY: begin
          if (do_load) state <= state_after_load;
        end
        DRAIN: begin
          if (validOut && outReady) begin
            packetDone <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_encrypt_tx.sv
// Scoreboard bench for lfsr_encrypt_tx: the expected packet is pushed when a
// start is driven and popped on every accepted output byte.
module tb_lfsr_encrypt_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] seed;
  logic [2:0] tap_sel;
  logic [7:0] plainByte;
  logic       plainValid;
  logic       plainReady;
  logic [7:0] encryptByte;
  logic       validOut;
  logic       outReady;
  logic       busy;
  logic       packetDone;
  logic       cfgErr;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs[32];
  logic [7:0] keys[32];
  logic [7:0] ref_obs[32];
  int         acc;

  lfsr_encrypt_tx dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .tap_sel(tap_sel),
    .plainByte(plainByte), .plainValid(plainValid), .plainReady(plainReady),
    .encryptByte(encryptByte), .validOut(validOut), .outReady(outReady),
    .busy(busy), .packetDone(packetDone), .cfgErr(cfgErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] model_taps(input logic [2:0] ts);
    case (ts)
      3'd0: return 5'h1E;
      3'd1: return 5'h1D;
      3'd2: return 5'h1B;
      3'd3: return 5'h17;
      3'd4: return 5'h14;
      default: return 5'h12;
    endcase
  endfunction

  // Drive one packet. rnd_o: random outReady stalls; rnd_p: plainValid gaps;
  // poke: pulse start (with a bad seed) mid-packet; abort_at: reset after
  // that many accepted bytes (0 = run to completion).
  task automatic run_pkt(input logic [4:0] sd, input logic [2:0] ts, input bit rnd_o,
                         input bit rnd_p, input bit poke, input int abort_at);
    logic [4:0] l, tp;
    logic [7:0] pt, e, held_b;
    int  pidx, last_cyc;
    bit  done, held, first;
    tp = model_taps(ts);
    l  = sd;
    exp_q.delete();
    for (int i = 0; i < 32; i++) begin
      pt      = (i < 7) ? 8'h7E : 8'(i - 7);
      keys[i] = {(i < 7) ? 3'b000 : 3'b100, l};
      exp_q.push_back(pt ^ keys[i]);
      l = {l[3:0], ^(l & tp)};
      obs[i] = 8'h00;
    end
    @(posedge clk); #1;
    seed = sd; tap_sel = ts; start = 1'b1; outReady = 1'b1; plainValid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    acc = 0; pidx = 0; last_cyc = -100; done = 0; held = 0; first = 1;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      outReady   = rnd_o ? 1'($urandom_range(0, 1)) : 1'b1;
      plainValid = (pidx < 25) && (rnd_p ? 1'($urandom_range(0, 1)) : 1'b1);
      plainByte  = (pidx < 25) ? 8'(pidx) : 8'hA5;
      start      = poke && (cyc == 5);
      seed       = poke ? 5'd0 : sd;
      @(negedge clk);
      if (first) chk("first_valid", 32'(validOut), 1);
      first = 0;
      if (held) begin
        chk("hold_valid", 32'(validOut), 1);
        chk("hold_byte", 32'(encryptByte), 32'(held_b));
      end
      if (poke && cyc == 6) chk("busy_start_cfgerr", 32'(cfgErr), 0);
      if (validOut && !outReady) chk("ready_while_stalled", 32'(plainReady), 0);
      if (packetDone) begin
        chk("done_gap", 32'(cyc - last_cyc), 1);
        done = 1;
      end
      if (validOut && outReady) begin
        if (exp_q.size() == 0) chk("extra_byte", 32'(encryptByte), 32'hFFFF);
        else begin
          e = exp_q.pop_front();
          chk("byte", 32'(encryptByte), 32'(e));
        end
        if (acc < 32) obs[acc] = encryptByte;
        acc++;
        last_cyc = cyc;
      end
      held   = validOut && !outReady;
      held_b = encryptByte;
      if (plainValid && plainReady) pidx++;
      if (abort_at != 0 && acc == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        chk("abort_valid", 32'(validOut), 0);
        chk("abort_busy", 32'(busy), 0);
        rst = 1'b0;
        start = 1'b0;
        exp_q.delete();
        return;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    plainValid = 1'b0;
    if (!done) chk("timeout_packetDone", 0, 1);
    chk("accepted_count", 32'(acc), 32);
    chk("queue_empty", 32'(exp_q.size()), 0);
  endtask

  task automatic bad_start(input logic [4:0] sd, input logic [2:0] ts);
    @(posedge clk); #1;
    seed = sd; tap_sel = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("cfgerr_pulse", 32'(cfgErr), 1);
    chk("cfgerr_busy", 32'(busy), 0);
    @(negedge clk);
    chk("cfgerr_one_cycle", 32'(cfgErr), 0);
    chk("cfgerr_no_valid", 32'(validOut), 0);
  endtask

  function automatic int seq_diff();
    int n = 0;
    for (int i = 0; i < 32; i++) if (obs[i] !== ref_obs[i]) n++;
    return n;
  endfunction

  initial begin
    int nm;
    rst = 1'b1; start = 1'b0; seed = 5'd0; tap_sel = 3'd0;
    plainByte = 8'h00; plainValid = 1'b0; outReady = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(validOut), 0);
    chk("rst_byte", 32'(encryptByte), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(plainReady), 0);
    chk("rst_done", 32'(packetDone), 0);
    chk("rst_cfgerr", 32'(cfgErr), 0);

    // Basic packet, known first bytes.
    run_pkt(5'h01, 3'd0, 0, 0, 0, 0);
    chk("byte0", 32'(obs[0]), 32'h7F);
    chk("byte1", 32'(obs[1]), 32'h7C);
    chk("byte2", 32'(obs[2]), 32'h7B);
    for (int i = 0; i < 32; i++) ref_obs[i] = obs[i];

    // All taps, two seeds; decrypt payload with the model key stream.
    for (int t = 0; t < 6; t++) begin
      for (int s = 0; s < 2; s++) begin
        run_pkt(s ? 5'h1F : 5'h01, 3'(t), 0, 0, 0, 0);
        nm = 0;
        for (int i = 7; i < 32; i++) if ((obs[i] ^ keys[i]) !== 8'(i - 7)) nm++;
        chk("decrypt", 32'(nm), 0);
      end
    end

    // Output stalls, source gaps, both plus a start while busy.
    run_pkt(5'h01, 3'd0, 1, 0, 0, 0);
    chk("stall_seq", 32'(seq_diff()), 0);
    run_pkt(5'h01, 3'd0, 0, 1, 0, 0);
    chk("gap_seq", 32'(seq_diff()), 0);
    run_pkt(5'h01, 3'd0, 1, 1, 1, 0);
    chk("stall_gap_poke_seq", 32'(seq_diff()), 0);

    // Rejected configurations.
    bad_start(5'h00, 3'd0);
    bad_start(5'h01, 3'd6);
    bad_start(5'h01, 3'd7);

    // Abort at byte 10, then restart.
    run_pkt(5'h01, 3'd0, 0, 0, 0, 10);
    run_pkt(5'h01, 3'd0, 0, 0, 0, 0);
    chk("restart_byte0", 32'(obs[0]), 32'h7F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
